lrn_pad_writer: RTL

- Padding unit that consumes the LRN mapper's `normalized_layer` pulse.
- The normalized ifmap already sits in the GLB, with interior pixels at padded-layout addresses.
- This block writes zero to every border (padding) location of that padded layout, for all batches and maps.
- It then pulses `padded_layer` so the next layer can start fetching the padded ifmap.

---
 rtl/lrn_pad_writer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/lrn_pad_writer.sv
// Zero-fills the border cells of the padded LRN ifmap in the GLB, then pulses padded_layer.
// Scans the padded layout in address order; interior cells are skipped without a write.
module lrn_pad_writer #(
    parameter int unsigned N_WIDTH        = 2,
    parameter int unsigned M_WIDTH        = 10,
    parameter int unsigned E_WIDTH        = 6,
    parameter int unsigned F_WIDTH        = 6,
    parameter int unsigned V_WIDTH        = 2,
    parameter int unsigned ADDR_BUS_WIDTH = 20,
    parameter int unsigned DATA_WIDTH     = 16
) (
    input  logic                      core_clk,
    input  logic                      reset,
    input  logic                      start_padding,
    input  logic [N_WIDTH-1:0]        dim4,
    input  logic [M_WIDTH-1:0]        dim3,
    input  logic [E_WIDTH-1:0]        dim2,
    input  logic [F_WIDTH-1:0]        dim1,
    input  logic [V_WIDTH-1:0]        padding_num,
    input  logic                      mem_stall,
    output logic [ADDR_BUS_WIDTH-1:0] w_addr,
    output logic [DATA_WIDTH-1:0]     w_data,
    output logic                      w_enable,
    output logic                      busy,
    output logic                      padded_layer
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                    state;
    logic [N_WIDTH-1:0]        n_lat;
    logic [M_WIDTH-1:0]        m_lat;
    logic [V_WIDTH-1:0]        p_lat;
    logic [E_WIDTH-1:0]        ph;
    logic [F_WIDTH-1:0]        pw;
    logic [E_WIDTH-1:0]        row_hi;
    logic [F_WIDTH-1:0]        col_hi;
    logic [E_WIDTH-1:0]        row;
    logic [F_WIDTH-1:0]        col;
    logic [M_WIDTH-1:0]        m_cnt;
    logic [N_WIDTH-1:0]        n_cnt;
    logic [ADDR_BUS_WIDTH-1:0] addr;

    logic border;
    logic advance;
    logic row_last;
    logic col_last;
    logic m_last;
    logic n_last;
    logic zero_cfg;

    // Border classification and wrap detection from the registered counters
    assign border   = (row < E_WIDTH'(p_lat)) || (row >= row_hi) ||
                      (col < F_WIDTH'(p_lat)) || (col >= col_hi);
    assign advance  = !border || !mem_stall;
    assign row_last = (row == ph - E_WIDTH'(1));
    assign col_last = (col == pw - F_WIDTH'(1));
    assign m_last   = (m_cnt == m_lat - M_WIDTH'(1));
    assign n_last   = (n_cnt == n_lat - N_WIDTH'(1));
    assign zero_cfg = (padding_num == '0) || (dim4 == '0) || (dim3 == '0) ||
                      (dim2 == '0) || (dim1 == '0);

    assign w_addr       = addr;
    assign w_data       = '0;
    assign w_enable     = (state == SCAN) && border;
    assign busy         = (state == SCAN);
    assign padded_layer = (state == DONE);

    always_ff @(posedge core_clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            n_lat  <= '0;
            m_lat  <= '0;
            p_lat  <= '0;
            ph     <= '0;
            pw     <= '0;
            row_hi <= '0;
            col_hi <= '0;
            row    <= '0;
            col    <= '0;
            m_cnt  <= '0;
            n_cnt  <= '0;
            addr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_padding) begin
                        n_lat  <= dim4;
                        m_lat  <= dim3;
                        p_lat  <= padding_num;
                        ph     <= dim2 + E_WIDTH'({padding_num, 1'b0});
                        pw     <= dim1 + F_WIDTH'({padding_num, 1'b0});
                        row_hi <= dim2 + E_WIDTH'(padding_num);
                        col_hi <= dim1 + F_WIDTH'(padding_num);
                        state  <= zero_cfg ? DONE : SCAN;
                    end
                end
                SCAN: begin
                    if (advance) begin
                        addr <= addr + ADDR_BUS_WIDTH'(1);
                        if (row_last) begin
                            row <= '0;
                            if (col_last) begin
                                col <= '0;
                                if (m_last) begin
                                    m_cnt <= '0;
                                    n_cnt <= n_cnt + N_WIDTH'(1);
                                    if (n_last) begin
                                        state <= DONE;
                                    end
                                end else begin
                                    m_cnt <= m_cnt + M_WIDTH'(1);
                                end
                            end else begin
                                col <= col + F_WIDTH'(1);
                            end
                        end else begin
                            row <= row + E_WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    row   <= '0;
                    col   <= '0;
                    m_cnt <= '0;
                    n_cnt <= '0;
                    addr  <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
